nn_argmax_collector: RTL and testbench
======================================

// Module: nn_argmax_collector
// PURPOSE
// - Downstream stage of the SRNN core. Consumes its serial y-vector stream (IEEE-754 single, GROUP words per
//   timestep) and reports, per timestep, the index and value of the largest element.
// - Results are buffered in a small FIFO and drained with a valid/ready handshake toward the classifier/host.
// PARAMETERS
// - GROUP       3  words per timestep (elements compared per result), >=2
// - NUM_GROUPS  3  timesteps per frame; out_last marks the final one
// - FIFO_DEPTH  4  result FIFO entries, power of 2, >=2
// PORTS
// - clk        in   1   single clock, rising edge
// - rst        in   1   asynchronous, active-high reset
// - in_valid   in   1   in_data valid this cycle (no backpressure; gaps allowed)
// - in_data    in   32  IEEE-754 single-precision element
// - out_valid  out  1   FIFO head valid
// - out_ready  in   1   downstream accepts head when out_valid&&out_ready
// - out_idx    out  $clog2(GROUP)  argmax index within group (0..GROUP-1)
// - out_max    out  32  winning element, bit-exact copy of the input word
// - out_last   out  1   head result belongs to last group of a frame
// - overflow   out  1   sticky: a result was dropped because the FIFO was full
// BEHAVIOUR
// - Reset: out_valid=0, out_idx=0, out_max=0, out_last=0, overflow=0, FIFO empty, counters 0, FSM IDLE.
//   Async assert; in-flight group and FIFO contents are discarded.
// - FSM: IDLE (no element of current group seen) -> ACC on in_valid; ACC -> IDLE when the GROUP-th
//   element arrives (result pushed that same edge); stays ACC across in_valid gaps. No timeout.
// - elem_cnt 0..GROUP-1 wraps per group; grp_cnt 0..NUM_GROUPS-1 increments per pushed group, wraps to 0.
//   A dropped result still advances grp_cnt. out_last = (grp_cnt==NUM_GROUPS-1) at push time.
// - Compare (no DesignWare, pure integer logic): sign-magnitude order. +0 == -0. NaN (exp=0xFF, mant!=0)
//   ranks below -inf and never replaces a non-NaN. Element 0 initializes the running max.
// - Ties: the earlier index is kept (strictly-greater replaces).
// - Result for a group includes the word arriving in its final cycle (combinational merge into the push).
// - Latency: last word at edge N -> out_valid=1 after edge N (visible in cycle N+1) if FIFO was empty.
// - FIFO: out_* are driven from head register/array; pop on out_valid&&out_ready. With the FIFO full,
//   push+pop in the same cycle both succeed. Push with full and no pop: result dropped, overflow<=1
//   (cleared only by rst). Pop with empty: ignored.
// - out_* hold stable while out_valid&&!out_ready.
// - All-NaN group: out_idx=0, out_max=element 0.
// CONFIGURATION
// - NN_ARGMAX_TIE_LAST_EN defined: ties resolve to the LATEST index (greater-or-equal replaces; +0/-0
//   still count as equal). NaN rule unchanged. Undefined (default): earliest index wins as above.
// TESTING
// - Basic: frame {1.0,2.0,0.5 | 0,0x3F000000,0 | 3.0,3.0,1.0} (hex 3F800000,40000000,3F000000 ...)
//   with out_ready=1 -> (idx1,40000000,last0),(idx1,3F000000,last0),(idx0,40400000,last1); 2nd frame's
//   first result has last0.
// - Signs/zeros/NaN: {BF800000,80000000,00000000} -> idx1, 80000000 (tie-first); {7FC00000,BF800000,7FC00000}
//   -> idx1, BF800000; all 7FC00000 -> idx0.
// - Gaps: same group as Basic with in_valid low 5 cycles between words -> identical result, out_valid
//   exactly one cycle after the 3rd word.
// - Backpressure/overflow: out_ready=0, send 5 groups -> 4 held in order, 5th dropped, overflow=1; then
//   out_ready=1 -> 4 results drain, out_last follows grp_cnt (5th drop advanced grp_cnt).
// - Full push+pop: FIFO full, out_ready=1 on the cycle a new group completes -> no drop, overflow stays 0.
// - Reset mid-group: 2 words sent, rst pulse, then {0.5,1.0,0.25} -> idx1, 3F800000, out_last=0;
//   rerun tie case with NN_ARGMAX_TIE_LAST_EN -> {3.0,3.0,1.0} gives idx1.

Source files
------------

// File: rtl/nn_argmax_collector_if.sv
// Stream and result bus for nn_argmax_collector.
// The slave modport is the collector's view; the master modport is the producer/consumer view.
interface nn_argmax_collector_if #(
  parameter int GROUP = 3
);
  localparam int IDX_W = (GROUP > 1) ? $clog2(GROUP) : 1;

  logic             in_valid;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [31:0]      out_max;
  logic             out_last;
  logic             overflow;

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_idx, out_max, out_last, overflow
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_idx, out_max, out_last, overflow
  );
endinterface

// File: rtl/nn_argmax_collector.sv
// Per-timestep argmax over a serial IEEE-754 stream, with results buffered in a small FIFO.
// Define NN_ARGMAX_TIE_LAST_EN to make ties resolve to the latest index instead of the earliest.
module nn_argmax_collector #(
  parameter int GROUP      = 3,
  parameter int NUM_GROUPS = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  nn_argmax_collector_if.slave bus
);
  localparam int IDX_W = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam int GRP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] elem_cnt;
  logic [GRP_W-1:0] grp_cnt;
  logic [31:0]      run_max;
  logic [IDX_W-1:0] run_idx;

  logic             final_word;
  logic             take;
  logic [31:0]      merged_max;
  logic [IDX_W-1:0] merged_idx;
  logic             push;

  logic [IDX_W-1:0] mem_idx  [FIFO_DEPTH];
  logic [31:0]      mem_max  [FIFO_DEPTH];
  logic             mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic             overflow_q;

  function automatic logic is_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
  endfunction

  // Sign-magnitude to two's complement; both zeros map to 0 so they compare equal.
  function automatic logic signed [32:0] order_key(input logic [31:0] w);
    logic signed [32:0] mag;
    mag = {2'b00, w[30:0]};
    if (w[31] && (w[30:0] != 31'd0)) begin
      return -mag;
    end
    return mag;
  endfunction

  function automatic logic replaces(input logic [31:0] cand, input logic [31:0] cur);
    if (is_nan(cand)) begin
      return 1'b0;
    end
    if (is_nan(cur)) begin
      return 1'b1;
    end
`ifdef NN_ARGMAX_TIE_LAST_EN
    return order_key(cand) >= order_key(cur);
`else
    return order_key(cand) > order_key(cur);
`endif
  endfunction

  always_comb begin
    final_word = bus.in_valid && (elem_cnt == IDX_W'(GROUP - 1));
    take       = (state == IDLE) || replaces(bus.in_data, run_max);
    merged_max = take ? bus.in_data : run_max;
    merged_idx = take ? elem_cnt : run_idx;
    push       = final_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid && !final_word) state_next = ACC;
      ACC:  if (final_word) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_cnt <= '0;
      grp_cnt  <= '0;
      run_max  <= '0;
      run_idx  <= '0;
    end else begin
      if (bus.in_valid) begin
        run_max  <= merged_max;
        run_idx  <= merged_idx;
        elem_cnt <= final_word ? '0 : elem_cnt + 1'b1;
      end
      if (push) begin
        grp_cnt <= (grp_cnt == GRP_W'(NUM_GROUPS - 1)) ? '0 : grp_cnt + 1'b1;
      end
    end
  end

  // A pop frees a slot on the same edge, so a push into a full FIFO is accepted when draining.
  always_comb begin
    full    = (count == CNT_W'(FIFO_DEPTH));
    empty   = (count == '0);
    pop     = !empty && bus.out_ready;
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_idx[i]  <= '0;
        mem_max[i]  <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      if (push_ok) begin
        mem_idx[wr_ptr]  <= merged_idx;
        mem_max[wr_ptr]  <= merged_max;
        mem_last[wr_ptr] <= (grp_cnt == GRP_W'(NUM_GROUPS - 1));
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.out_valid = !empty;
    bus.out_idx   = mem_idx[rd_ptr];
    bus.out_max   = mem_max[rd_ptr];
    bus.out_last  = mem_last[rd_ptr];
    bus.overflow  = overflow_q;
  end
endmodule

// File: tb/tb_nn_argmax_collector.sv
// Scoreboard bench for nn_argmax_collector: a real-valued argmax model plus a FIFO occupancy model
// predict each result; a monitor compares on every handshake.
module tb_nn_argmax_collector;
  localparam int GROUP      = 3;
  localparam int NUM_GROUPS = 3;
  localparam int FIFO_DEPTH = 4;

  typedef logic [31:0] grp_t [GROUP];
  typedef struct {
    int          idx;
    logic [31:0] max;
    logic        last;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   ready_mode = 3;

  res_t        exp_q[$];
  logic [31:0] m_words[$];
  int          m_grp = 0;
  int          m_count = 0;
  logic        m_ovf = 1'b0;

  nn_argmax_collector_if #(.GROUP(GROUP)) bus ();

  nn_argmax_collector #(
    .GROUP(GROUP), .NUM_GROUPS(NUM_GROUPS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 0);
  endfunction

  function automatic real to_real(input logic [31:0] w);
    int  e;
    real mag;
    e = int'(w[30:23]);
    if (e == 255)    mag = 1.0e300;
    else if (e == 0) mag = real'(w[22:0]) * (2.0 ** (-149));
    else             mag = (1.0 + real'(w[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return w[31] ? -mag : mag;
  endfunction

  // Largest non-NaN value wins; NaNs rank lowest; all-NaN falls back to element 0.
  function automatic res_t ref_argmax(input logic [31:0] w[$]);
    res_t r;
    logic found;
    real  best;
    r.idx = 0; r.max = w[0]; r.last = 1'b0;
    found = 1'b0; best = 0.0;
    for (int i = 0; i < w.size(); i++) begin
      if (!is_nan(w[i])) begin
`ifdef NN_ARGMAX_TIE_LAST_EN
        if (!found || to_real(w[i]) >= best) begin
`else
        if (!found || to_real(w[i]) > best) begin
`endif
          found = 1'b1; best = to_real(w[i]); r.idx = i; r.max = w[i];
        end
      end
    end
    return r;
  endfunction

  // Reference model: evaluates what the coming edge does to the result FIFO.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_words.delete(); exp_q.delete();
        m_grp = 0; m_count = 0; m_ovf = 1'b0;
      end else begin
        logic pop_m;
        logic push_m;
        res_t r;
        pop_m  = (m_count > 0) && bus.out_ready;
        push_m = 1'b0;
        if (bus.in_valid) begin
          m_words.push_back(bus.in_data);
          if (m_words.size() == GROUP) begin
            r = ref_argmax(m_words);
            r.last = (m_grp == NUM_GROUPS - 1);
            m_grp = (m_grp + 1) % NUM_GROUPS;
            m_words.delete();
            push_m = 1'b1;
          end
        end
        if (push_m) begin
          if (m_count < FIFO_DEPTH || pop_m) begin
            exp_q.push_back(r);
            m_count++;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (pop_m) m_count--;
      end
    end
  end

  // Monitor: one ns after the falling edge, inputs for the next edge are settled.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        checkOutput("out_valid", 32'(bus.out_valid), 32'(m_count != 0));
        checkOutput("overflow", 32'(bus.overflow), 32'(m_ovf));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_result", 32'(bus.out_valid), 32'd0);
          end else begin
            res_t r;
            r = exp_q.pop_front();
            checkOutput("out_idx", 32'(bus.out_idx), 32'(r.idx));
            checkOutput("out_max", bus.out_max, r.max);
            checkOutput("out_last", 32'(bus.out_last), 32'(r.last));
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ready_mode == 0)      bus.out_ready = 1'b1;
      else if (ready_mode == 1) bus.out_ready = 1'b0;
      else if (ready_mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input grp_t g, input int gap);
    for (int i = 0; i < GROUP; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = g[i];
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while ((m_count != 0 || exp_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_word(input logic [31:0] prev);
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7F80_0000;
      3: return 32'hFF80_0000;
      4: return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 8388607))};
      5: return prev;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    grp_t g;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_idx", 32'(bus.out_idx), 32'd0);
    checkOutput("reset_out_max", bus.out_max, 32'd0);
    checkOutput("reset_out_last", 32'(bus.out_last), 32'd0);
    checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;

    g = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000}; applyStimulus(g, 0);
    g = '{32'h0000_0000, 32'h3F00_0000, 32'h0000_0000}; applyStimulus(g, 0);
    g = '{32'h4040_0000, 32'h4040_0000, 32'h3F80_0000}; applyStimulus(g, 0);
    g = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000}; applyStimulus(g, 0);
    g = '{32'hBF80_0000, 32'h8000_0000, 32'h0000_0000}; applyStimulus(g, 1);
    g = '{32'h7FC0_0000, 32'hBF80_0000, 32'h7FC0_0000}; applyStimulus(g, 0);
    g = '{32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000}; applyStimulus(g, 0);
    g = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000}; applyStimulus(g, 5);
    idle(3);
    wait_drain("drain_directed", 100);

    $display("[TB] full FIFO with simultaneous push and pop");
    ready_mode = 3;
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int n = 0; n < FIFO_DEPTH; n++) begin
      g = '{$urandom, $urandom, $urandom}; applyStimulus(g, 0);
    end
    g = '{32'h4100_0000, 32'hC100_0000, 32'h4110_0000};
    for (int i = 0; i < GROUP; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = g[i];
      bus.out_ready = (i == GROUP - 1);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    checkOutput("full_push_pop_overflow", 32'(bus.overflow), 32'd0);
    ready_mode = 0;
    idle(2);
    wait_drain("drain_full_push_pop", 100);

    $display("[TB] backpressure and overflow");
    ready_mode = 1;
    for (int n = 0; n < FIFO_DEPTH + 1; n++) begin
      g = '{rand_word(32'h1), rand_word(32'h2), rand_word(32'h3)}; applyStimulus(g, 0);
    end
    idle(3);
    #1;
    checkOutput("overflow_sticky", 32'(bus.overflow), 32'd1);
    ready_mode = 0;
    idle(2);
    wait_drain("drain_backpressure", 100);
    g = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000}; applyStimulus(g, 0);
    idle(3);
    wait_drain("drain_after_overflow", 100);

    $display("[TB] reset in the middle of a group");
    g = '{32'h4080_0000, 32'h40A0_0000, 32'h0};
    applyStimulus(g, 0);
    pulse_reset();
    idle(1);
    checkOutput("reset_clears_overflow", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = g[i];
    end
    pulse_reset();
    g = '{32'h3F00_0000, 32'h3F80_0000, 32'h3E80_0000}; applyStimulus(g, 0);
    idle(3);
    wait_drain("drain_after_reset", 100);

    $display("[TB] randomized traffic");
    ready_mode = 2;
    for (int n = 0; n < 80; n++) begin
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      w0 = rand_word($urandom);
      w1 = rand_word(w0);
      w2 = rand_word(w1);
      g = '{w0, w1, w2};
      applyStimulus(g, $urandom_range(0, 2));
    end
    ready_mode = 0;
    idle(3);
    wait_drain("drain_random", 200);
    checkOutput("model_count_zero", 32'(m_count), 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
